// File: rtl/puf_cnt_pkg.sv
// Shared types and helpers for the PUF window counter: FSM state type,
// default widths and the pairwise count comparison.
package puf_cnt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StCount,
        StDone
    } state_e;

    localparam int unsigned DefNumCh = 2;
    localparam int unsigned DefCntW  = 22;
    localparam int unsigned DefWinW  = 24;

    // Unsigned compare of two zero-extended counts; returns {a_greater, a_equal}.
    function automatic logic [1:0] pair_cmp(input logic [63:0] a, input logic [63:0] b);
        return {a > b, a == b};
    endfunction

endpackage

// File: rtl/puf_window_counter_if.sv
// Request/status bundle between the PUF mux side and the window counter.
// master: the requester driving start/window_len/ch_pulse; slave: the counter.
interface puf_window_counter_if
    import puf_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH = DefNumCh,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned WIN_W  = DefWinW
);

    logic                     start;
    logic [WIN_W-1:0]         window_len;
    logic [NUM_CH-1:0]        ch_pulse;
    logic                     busy;
    logic                     done;
    logic [NUM_CH*CNT_W-1:0]  counts;
    logic [NUM_CH-1:0]        sat;
    logic [NUM_CH/2-1:0]      resp;
    logic [NUM_CH/2-1:0]      tie;

    modport master (
        output start, window_len, ch_pulse,
        input  busy, done, counts, sat, resp, tie
    );

    modport slave (
        input  start, window_len, ch_pulse,
        output busy, done, counts, sat, resp, tie
    );

endinterface

// File: rtl/puf_sat_counter.sv
// One channel of the window counter: saturating up-counter with a sticky
// saturation flag. clr has priority over inc.
module puf_sat_counter
    import puf_cnt_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // Next count: clear, or increment unless already all-ones (then flag saturation).
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/puf_window_counter.sv
// Multi-channel PUF window counter. Counts ch_pulse over a programmable window
// and produces per-pair response (even > odd) and tie bits.
// Optional feature macro PUF_EDGE_COUNT_EN: count synchronized rising edges
// instead of high levels.
module puf_window_counter
    import puf_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH = DefNumCh,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned WIN_W  = DefWinW
) (
    input  logic clk,
    input  logic reset,
    puf_window_counter_if.slave bus_io
);

    localparam int unsigned NumPair = NUM_CH / 2;

    state_e                  state_q, state_d;
    logic [WIN_W-1:0]        len_q, len_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic                    busy_q, done_q;
    logic [NumPair-1:0]      resp_q, tie_q;
    logic [NumPair-1:0]      resp_now, tie_now;
    logic [1:0]              cmp;
    logic [NUM_CH-1:0]       pulse_eff;
    logic [NUM_CH-1:0]       inc;
    logic                    clr;
    logic [NUM_CH*CNT_W-1:0] counts;
    logic [NUM_CH-1:0]       sat;

`ifdef PUF_EDGE_COUNT_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;

    // Two-flop synchronizer plus previous-value flop for rising-edge detect;
    // deliberately untouched by CLEAR so edges straddling a window are not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= bus_io.ch_pulse;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_eff = sync2_q & ~prev_q;
`else
    assign pulse_eff = bus_io.ch_pulse;
`endif

    assign clr = (state_q == StClear);
    assign inc = {NUM_CH{state_q == StCount}} & pulse_eff;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        puf_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .inc   (inc[i]),
            .count (counts[i*CNT_W +: CNT_W]),
            .sat   (sat[i])
        );
    end

    // Pairwise compare of the live counts (only consumed in DONE).
    always_comb begin
        resp_now = '0;
        tie_now  = '0;
        cmp      = '0;
        for (int k = 0; k < NumPair; k++) begin
            cmp = pair_cmp(64'(counts[2*k*CNT_W +: CNT_W]),
                           64'(counts[(2*k+1)*CNT_W +: CNT_W]));
            resp_now[k] = cmp[1];
            tie_now[k]  = cmp[0];
        end
    end

    // Next-state logic: accept start in idle, clear, count down the window, report.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        win_d   = win_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    len_d   = bus_io.window_len;
                    state_d = StClear;
                end
            end
            StClear: begin
                if (len_q == '0) begin
                    state_d = StDone;
                end else begin
                    win_d   = len_q;
                    state_d = StCount;
                end
            end
            StCount: begin
                win_d = win_q - WIN_W'(1);
                // win_q == 1 is the last sampled cycle.
                if (win_q == WIN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, window and status registers; resp/tie captured in DONE and held after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= '0;
            tie_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            win_q   <= win_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            if (state_q == StDone) begin
                resp_q <= resp_now;
                tie_q  <= tie_now;
            end
        end
    end

    assign bus_io.busy   = busy_q;
    assign bus_io.done   = done_q;
    assign bus_io.counts = counts;
    assign bus_io.sat    = sat;
    // Counts are final (registered) during DONE, so expose the compare directly then.
    assign bus_io.resp   = done_q ? resp_now : resp_q;
    assign bus_io.tie    = done_q ? tie_now : tie_q;

endmodule

// File: tb/tb_puf_window_counter.sv
// Randomized self-checking bench for puf_window_counter against a window-sum model.
module tb_puf_window_counter;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WIN_W   = 8;
    localparam int unsigned NP      = NUM_CH / 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          HIST_N  = 16384;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    puf_window_counter_if #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .WIN_W  (WIN_W)
    ) bus_if ();

    puf_window_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .WIN_W  (WIN_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int floor_e = 0;
    logic [NUM_CH-1:0] hist [HIST_N];
    int mode [NUM_CH];
    int per  [NUM_CH];

    logic [NUM_CH*CNT_W-1:0] exp_cnt;
    logic [NUM_CH-1:0]       exp_sat;
    logic [NP-1:0]           exp_resp, exp_tie;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
        end
    endtask

    // Channel modes: 0 low, 1 high, 2 random, 3 square wave of period per[i].
    function automatic logic [NUM_CH-1:0] gen_pulse(input int e);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode[i])
                0:       v[i] = 1'b0;
                1:       v[i] = 1'b1;
                2:       v[i] = 1'($urandom_range(0, 1));
                default: v[i] = ((e % per[i]) < (per[i] / 2));
            endcase
        end
        return v;
    endfunction

    task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
    endtask

    // Drive pulses for the next edge, advance one clock, record what was sampled.
    task automatic tick();
        bus_if.ch_pulse = gen_pulse(edge_n + 1);
        @(posedge clk);
        edge_n++;
        hist[edge_n] = reset ? '0 : bus_if.ch_pulse;
        #1;
    endtask

    function automatic bit pval(input int e, input int i);
        if (e < 1 || e <= floor_e) return 1'b0;
        return hist[e][i];
    endfunction

    // Reference: counts are the number of qualifying samples over edges t+2..t+1+w,
    // clipped at the maximum; saturation means the raw total exceeded it.
    task automatic model(input int t, input int w);
        int sum;
        int c [NUM_CH];
        exp_cnt = '0;
        exp_sat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = 0;
            for (int e = t + 2; e <= t + 1 + w; e++) begin
`ifdef PUF_EDGE_COUNT_EN
                if (pval(e - 2, i) && !pval(e - 3, i)) sum++;
`else
                if (pval(e, i)) sum++;
`endif
            end
            c[i] = (sum > CNT_MAX) ? CNT_MAX : sum;
            exp_sat[i] = (sum > CNT_MAX);
            exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(c[i]);
        end
        for (int k = 0; k < NP; k++) begin
            exp_resp[k] = (c[2*k] > c[2*k+1]);
            exp_tie[k]  = (c[2*k] == c[2*k+1]);
        end
    endtask

    task automatic check_results(input string ph);
        for (int i = 0; i < NUM_CH; i++) begin
            check_val({ph, "_count"}, 64'(bus_if.counts[i*CNT_W +: CNT_W]),
                      64'(exp_cnt[i*CNT_W +: CNT_W]));
        end
        check_val({ph, "_sat"},  64'(bus_if.sat),  64'(exp_sat));
        check_val({ph, "_resp"}, 64'(bus_if.resp), 64'(exp_resp));
        check_val({ph, "_tie"},  64'(bus_if.tie),  64'(exp_tie));
    endtask

    // One measurement; optionally pokes start (and window_len) while busy.
    task automatic run_meas(input int w, input bit poke);
        int t;
        bus_if.start      = 1'b1;
        bus_if.window_len = WIN_W'(w);
        tick();
        t = edge_n;
        bus_if.start = 1'b0;
        check_val("busy_after_start", 64'(bus_if.busy), 64'd1);
        check_val("done_after_start", 64'(bus_if.done), 64'd0);
        for (int k = 1; k <= w + 2; k++) begin
            if (poke) begin
                bus_if.start      = 1'($urandom_range(0, 1));
                bus_if.window_len = WIN_W'($urandom_range(0, 255));
            end
            tick();
            if (edge_n == t + 1 + w) begin
                model(t, w);
                check_val("done_pulse", 64'(bus_if.done), 64'd1);
                check_val("busy_done",  64'(bus_if.busy), 64'd1);
                check_results("done");
            end else if (edge_n == t + 2 + w) begin
                check_val("done_idle", 64'(bus_if.done), 64'd0);
                check_val("busy_idle", 64'(bus_if.busy), 64'd0);
            end else begin
                check_val("done_early", 64'(bus_if.done), 64'd0);
                check_val("busy_run",   64'(bus_if.busy), 64'd1);
            end
        end
        bus_if.start = 1'b0;
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            tick();
            check_val("idle_busy", 64'(bus_if.busy), 64'd0);
            check_val("idle_done", 64'(bus_if.done), 64'd0);
        end
        check_results("hold");
    endtask

    initial begin
        for (int i = 0; i < HIST_N; i++) hist[i] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode[i] = 0;
            per[i]  = 2;
        end
        reset             = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.window_len = '0;
        bus_if.ch_pulse   = '0;
        tick();
        tick();
        check_val("rst_busy",   64'(bus_if.busy),   64'd0);
        check_val("rst_done",   64'(bus_if.done),   64'd0);
        check_val("rst_counts", 64'(bus_if.counts), 64'd0);
        check_val("rst_sat",    64'(bus_if.sat),    64'd0);
        check_val("rst_resp",   64'(bus_if.resp),   64'd0);
        check_val("rst_tie",    64'(bus_if.tie),    64'd0);
        floor_e = edge_n;
        reset = 1'b0;
        tick();

        // Basic: ch0 always high, ch1 every other cycle.
        set_modes(1, 3, 2, 0);
        per[1] = 2;
        run_meas(10, 1'b0);
        // Zero-length window with everything high.
        set_modes(1, 1, 1, 1);
        run_meas(0, 1'b0);
        // Saturation on ch0/ch2/ch3; ch1 idle.
        set_modes(1, 0, 1, 1);
        run_meas(40, 1'b0);
        // Handshake: start poked while busy and on the done cycle.
        set_modes(2, 2, 1, 0);
        run_meas(7, 1'b1);
        // Square waves of periods 2/4/6/6.
        set_modes(3, 3, 3, 3);
        per[0] = 2; per[1] = 4; per[2] = 6; per[3] = 6;
        run_meas(24, 1'b0);

        // Randomized measurements.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode[i] = int'($urandom_range(0, 3));
                per[i]  = 2 * int'($urandom_range(1, 4));
            end
            run_meas(int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a long window.
        set_modes(1, 2, 1, 3);
        per[3] = 4;
        bus_if.start      = 1'b1;
        bus_if.window_len = WIN_W'(100);
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 49; k++) tick();
        check_val("mid_busy", 64'(bus_if.busy), 64'd1);
        #2;
        reset = 1'b1;
        floor_e = edge_n;
        #1;
        check_val("mrst_busy",   64'(bus_if.busy),   64'd0);
        check_val("mrst_done",   64'(bus_if.done),   64'd0);
        check_val("mrst_counts", 64'(bus_if.counts), 64'd0);
        check_val("mrst_sat",    64'(bus_if.sat),    64'd0);
        check_val("mrst_resp",   64'(bus_if.resp),   64'd0);
        check_val("mrst_tie",    64'(bus_if.tie),    64'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("post_rst_done", 64'(bus_if.done), 64'd0);
            check_val("post_rst_busy", 64'(bus_if.busy), 64'd0);
        end
        run_meas(5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
